vga_scaled_frame_generator: RTL
===============================

VGA_SCALED_FRAME_GENERATOR -- requirements
Module: vga_scaled_frame_generator

Interface
REQ-001 The block SHALL have parameter H_SYNC, default 136, horizontal sync width in clocks.
REQ-002 The block SHALL have parameter H_BACK, default 200, horizontal back porch.
REQ-003 The block SHALL have parameter H_VIS, default 1280, visible pixels per line.
REQ-004 The block SHALL have parameter H_FRONT, default 64, horizontal front porch.
REQ-005 The block SHALL have parameter V_SYNC, default 3, vertical sync lines.
REQ-006 The block SHALL have parameter V_BACK, default 24, vertical back porch lines.
REQ-007 The block SHALL have parameter V_VIS, default 800, visible lines.
REQ-008 The block SHALL have parameter V_FRONT, default 1, vertical front porch lines.
REQ-009 The block SHALL have parameter X_START, default 600, h_cnt at which box pixel 0 appears on vga_rgb.
REQ-010 The block SHALL have parameter Y_START, default 139, v_cnt of the first box line.
REQ-011 The block SHALL have parameter BOX_W, default 752, box width; legal range 1..1024.
REQ-012 The block SHALL have parameter BOX_H, default 576, box height in displayed lines.
REQ-013 The block SHALL have parameter PIX_W, default 12, pixel width in bits; legal range 1..16.
REQ-014 The block SHALL have parameter RD_LAT, default 1, line-buffer read latency in clocks.
REQ-015 The block SHALL have parameter SYNC_POL, default 2'b00, sync polarity as {vs,hs}; 0 = active-low.
REQ-016 The block SHALL have ports clk in 1, pixel clock; and reset_n in 1, asynchronous active-low reset.
REQ-017 The block SHALL have port vga_hs out 1, horizontal sync; and vga_vs out 1, vertical sync.
REQ-018 The block SHALL have port vga_rgb out PIX_W, registered pixel.
REQ-019 The block SHALL have ports rd_address out 11, line-buffer address; and rd_data in 16, line-buffer data.
REQ-020 The block SHALL have ports g_req out 1, row fetch request; and g_ack in 1, fetch acknowledge.
REQ-021 The block SHALL have ports g_cache_row out 1, buffer half; and g_sdram_row out 10, source row.
REQ-022 The block SHALL have ports interlaced in 1, field_no in 1, and line_double in 1, mode inputs.
REQ-023 The block SHALL have ports border_rgb in PIX_W, border fill colour; and overrun out 1, sticky fetch-overrun flag.

Function
REQ-024 Counters SHALL satisfy: h_cnt wraps at H_TOTAL-1 (H_TOTAL = sum of the four H parameters); v_cnt increments on wrap and wraps at V_TOTAL-1; both 11 bits.
REQ-025 Sync timing SHALL be: hs active while h_cnt<H_SYNC; vs active while v_cnt<V_SYNC; active level per SYNC_POL; outputs combinational from the counters.
REQ-026 Mode sampling SHALL occur at h_cnt==0 && v_cnt==0: interlaced and line_double are latched into mode registers, and modes are never changed mid-frame.
REQ-027 Box coordinates SHALL be y_pos = v_cnt-Y_START; in-box when y_pos<BOX_H and the x offset is <BOX_W; displayed source row sr = line_double ? y_pos>>1 : y_pos.
REQ-028 Address generation SHALL use ax = h_cnt-(X_START-RD_LAT-2); in-box rd_address is registered as {sr[0], ax[9:0]}, otherwise 0.
REQ-029 Pixel output SHALL use cx = h_cnt-(X_START-1); vga_rgb is registered as rd_data[PIX_W-1:0] in-box, as border_rgb inside the visible area outside the box, and as 0 in blanking.
REQ-030 Fetch decision SHALL be made at h_cnt==0: fy = v_cnt-(Y_START-1); a fetch is due if fy<BOX_H and (line_double==0 or fy[0]==0); fr = line_double ? fy>>1 : fy.
REQ-031 Fetch targets SHALL be g_cache_row = fr[0] and g_sdram_row = interlaced ? fr[9:0] : {fr[9:1], field_no}; field_no is sampled at the fetch point.
REQ-032 The fetch handshake FSM SHALL have states IDLE, REQ and WAIT_LOW: IDLE with fetch due -> REQ (g_req=1, targets loaded); REQ with g_ack=1 -> WAIT_LOW (g_req=0); WAIT_LOW with g_ack=0 -> IDLE.
REQ-033 A fetch falling due outside IDLE SHALL be skipped: targets stay unchanged and overrun is set to 1, remaining 1 until reset.
REQ-034 g_cache_row and g_sdram_row SHALL be held stable for as long as g_req=1.

Reset
REQ-035 Asserting reset_n low SHALL asynchronously clear the counters, vga_rgb, rd_address, g_req, g_cache_row, g_sdram_row, overrun, the mode registers and the FSM (to IDLE); vga_hs and vga_vs then sit at active level.

Verification
REQ-036 Release reset with defaults -> hs active for 136 clocks per 1680-clock line; vs active for 3 lines of an 828-line frame.
REQ-037 Drive rd_data = address echo with 1-cycle latency -> vga_rgb shows x=0 at h_cnt 600 and x=751 at h_cnt 1351; border_rgb appears at h_cnt 1352..1615.
REQ-038 With interlaced=0, field_no=1, v_cnt 138, h_cnt 0 -> g_req=1, g_sdram_row=1, g_cache_row=0; with g_ack pulsed -> g_req=0 one cycle later.
REQ-039 With line_double=1 -> fetches occur only at v_cnt 138, 140, ...; lines 139 and 140 both read buffer half 0.
REQ-040 Hold g_ack=0 across two fetch points -> overrun=1 and g_sdram_row unchanged; assert reset_n mid-line -> all outputs immediately return to their reset values.

Source files
------------

// File: rtl/vga_scaled_frame_generator.sv
// Raster timing generator that places a line-buffered, optionally line-doubled
// picture box inside a bordered visible area and requests source rows ahead of display.
module vga_scaled_frame_generator #(
    parameter int         H_SYNC   = 136,
    parameter int         H_BACK   = 200,
    parameter int         H_VIS    = 1280,
    parameter int         H_FRONT  = 64,
    parameter int         V_SYNC   = 3,
    parameter int         V_BACK   = 24,
    parameter int         V_VIS    = 800,
    parameter int         V_FRONT  = 1,
    parameter int         X_START  = 600,
    parameter int         Y_START  = 139,
    parameter int         BOX_W    = 752,
    parameter int         BOX_H    = 576,
    parameter int         PIX_W    = 12,
    parameter int         RD_LAT   = 1,
    parameter logic [1:0] SYNC_POL = 2'b00
) (
    input  logic             clk,
    input  logic             reset_n,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic [PIX_W-1:0] vga_rgb,
    output logic [10:0]      rd_address,
    input  logic [15:0]      rd_data,
    output logic             g_req,
    input  logic             g_ack,
    output logic             g_cache_row,
    output logic [9:0]       g_sdram_row,
    input  logic             interlaced,
    input  logic             field_no,
    input  logic             line_double,
    input  logic [PIX_W-1:0] border_rgb,
    output logic             overrun
);

    localparam logic [10:0] H_LAST = 11'(H_SYNC + H_BACK + H_VIS + H_FRONT - 1);
    localparam logic [10:0] V_LAST = 11'(V_SYNC + V_BACK + V_VIS + V_FRONT - 1);
    localparam logic [10:0] AX_OFF = 11'(X_START - RD_LAT - 2);
    localparam logic [10:0] CX_OFF = 11'(X_START - 1);
    localparam logic [10:0] FY_OFF = 11'(Y_START - 1);
    localparam logic [10:0] HV_OFF = 11'(H_SYNC + H_BACK - 1);
    localparam logic [10:0] VV_OFF = 11'(V_SYNC + V_BACK);

    typedef enum logic [1:0] {IDLE, REQ, WAIT_LOW} state_t;

    state_t      state;
    logic [10:0] h_cnt, v_cnt;
    logic        mode_il, mode_ld;
    logic [10:0] y_pos, ax, cx, hv, vv, fy;
    logic        in_y, in_ax, in_cx, vis, sr0, fetch_due;
    logic [9:0]  fr;
    logic        hs_act, vs_act;
    logic        unused_bits;

    assign unused_bits = ^rd_data;

    assign hs_act = h_cnt < 11'(H_SYNC);
    assign vs_act = v_cnt < 11'(V_SYNC);
    assign vga_hs = SYNC_POL[0] ? hs_act : ~hs_act;
    assign vga_vs = SYNC_POL[1] ? vs_act : ~vs_act;

    // ax runs ahead of cx so the buffer read lands exactly on the pixel register
    assign y_pos = v_cnt - 11'(Y_START);
    assign in_y  = y_pos < 11'(BOX_H);
    assign sr0   = mode_ld ? y_pos[1] : y_pos[0];
    assign ax    = h_cnt - AX_OFF;
    assign cx    = h_cnt - CX_OFF;
    assign in_ax = in_y && (ax < 11'(BOX_W));
    assign in_cx = in_y && (cx < 11'(BOX_W));
    assign hv    = h_cnt - HV_OFF;
    assign vv    = v_cnt - VV_OFF;
    assign vis   = (hv < 11'(H_VIS)) && (vv < 11'(V_VIS));

    // a row is fetched one line before it is first displayed
    assign fy        = v_cnt - FY_OFF;
    assign fr        = mode_ld ? fy[10:1] : fy[9:0];
    assign fetch_due = (h_cnt == 11'd0) && (fy < 11'(BOX_H)) && (!mode_ld || !fy[0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt   <= '0;
            v_cnt   <= '0;
            mode_il <= 1'b0;
            mode_ld <= 1'b0;
        end else begin
            if (h_cnt == H_LAST) begin
                h_cnt <= '0;
                v_cnt <= (v_cnt == V_LAST) ? 11'd0 : v_cnt + 11'd1;
            end else begin
                h_cnt <= h_cnt + 11'd1;
            end
            if (h_cnt == 11'd0 && v_cnt == 11'd0) begin
                mode_il <= interlaced;
                mode_ld <= line_double;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_address <= '0;
            vga_rgb    <= '0;
        end else begin
            rd_address <= in_ax ? {sr0, ax[9:0]} : 11'd0;
            if (in_cx)
                vga_rgb <= rd_data[PIX_W-1:0];
            else if (vis)
                vga_rgb <= border_rgb;
            else
                vga_rgb <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            g_req       <= 1'b0;
            g_cache_row <= 1'b0;
            g_sdram_row <= '0;
            overrun     <= 1'b0;
        end else begin
            if (fetch_due && state != IDLE)
                overrun <= 1'b1;
            case (state)
                IDLE: if (fetch_due) begin
                    state       <= REQ;
                    g_req       <= 1'b1;
                    g_cache_row <= fr[0];
                    g_sdram_row <= mode_il ? fr : {fr[9:1], field_no};
                end
                REQ: if (g_ack) begin
                    state <= WAIT_LOW;
                    g_req <= 1'b0;
                end
                WAIT_LOW: if (!g_ack)
                    state <= IDLE;
                default: begin
                    state <= IDLE;
                    g_req <= 1'b0;
                end
            endcase
        end
    end

endmodule
